// File: rtl/i2s_rx_if.sv
// i2s_rx_if: serial I2S inputs and captured-sample outputs of the receiver
interface i2s_rx_if #(parameter int DATA_WIDTH = 16);
    logic                  ws_i;
    logic                  sdata_i;
    logic [DATA_WIDTH-1:0] left_o;
    logic [DATA_WIDTH-1:0] right_o;
    logic                  valid_o;
    logic                  err_o;
    modport master (output ws_i, sdata_i, input left_o, right_o, valid_o, err_o);
    modport slave  (input ws_i, sdata_i, output left_o, right_o, valid_o, err_o);
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: Philips I2S receiver; captures MSB-first slots, emits a frame pulse and a sticky framing error
module i2s_rx #(
    parameter int DATA_WIDTH = 16
) (
    input logic sclk_i,
    input logic rst_n_i,
    i2s_rx_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);
    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;
    state_t                state, state_n;
    logic                  ws_d, edge_w, good, valid_n, err_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] sr, sr_n, hold, hold_n, word, left_n, right_n;
    always_comb begin
        edge_w  = bus.ws_i != ws_d;
        // once the slot is full the register keeps the first DATA_WIDTH bits
        word    = (cnt < FULL) ? {sr[DATA_WIDTH-2:0], bus.sdata_i} : sr;
        good    = cnt >= FULL - CW'(1);
        state_n = state;
        cnt_n   = (cnt < FULL) ? cnt + CW'(1) : cnt;
        sr_n    = word;
        hold_n  = hold;
        left_n  = bus.left_o;
        right_n = bus.right_o;
        valid_n = 1'b0;
        err_n   = bus.err_o;
        case (state)
            SYNC: if (edge_w && ws_d) begin
                state_n = LEFT;
                cnt_n   = '0;
            end
            LEFT: if (edge_w) begin
                cnt_n   = '0;
                hold_n  = good ? word : hold;
                err_n   = bus.err_o | ~good;
                state_n = good ? RIGHT : SYNC;
            end
            RIGHT: if (edge_w) begin
                // a falling ws edge always restarts a left slot, even after a short right slot
                cnt_n   = '0;
                state_n = LEFT;
                err_n   = bus.err_o | ~good;
                valid_n = good;
                left_n  = good ? hold : bus.left_o;
                right_n = good ? word : bus.right_o;
            end
            default: state_n = SYNC;
        endcase
    end
    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= SYNC;
            ws_d        <= 1'b0;
            cnt         <= '0;
            sr          <= '0;
            hold        <= '0;
            bus.left_o  <= '0;
            bus.right_o <= '0;
            bus.valid_o <= 1'b0;
            bus.err_o   <= 1'b0;
        end else begin
            state       <= state_n;
            ws_d        <= bus.ws_i;
            cnt         <= cnt_n;
            sr          <= sr_n;
            hold        <= hold_n;
            bus.left_o  <= left_n;
            bus.right_o <= right_n;
            bus.valid_o <= valid_n;
            bus.err_o   <= err_n;
        end
    end
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: slot-level reference model plus directed and randomized I2S streams
module tb_i2s_rx;
    localparam int DW = 16;
    logic sclk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    i2s_rx_if #(.DATA_WIDTH(DW)) bus ();
    i2s_rx #(.DATA_WIDTH(DW)) dut (.sclk_i(sclk), .rst_n_i(rst_n), .bus(bus));
    always #5 sclk = ~sclk;

    // per-cycle stimulus: channel of each bit and the bit itself
    logic ws_q[$];
    logic bit_q[$];
    logic last_bit = 1'b0;
    logic [DW-1:0] cap_l[$];
    logic [DW-1:0] cap_r[$];

    // model state: bits of the current slot, whether a left slot was captured
    logic mbits[$];
    logic mws, armed, left_ok;
    logic [DW-1:0] lw, el, er;
    logic ev, ee;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack();
        logic [DW-1:0] w = '0;
        foreach (mbits[i]) w = {w[DW-2:0], mbits[i]};
        return w;
    endfunction

    initial begin
        mws = 0; armed = 0; left_ok = 0; lw = 0; el = 0; er = 0; ev = 0; ee = 0;
        forever begin
            @(posedge sclk or negedge rst_n);
            if (!rst_n) begin
                mws = 0; armed = 0; left_ok = 0; mbits.delete();
                el = 0; er = 0; ev = 0; ee = 0;
            end else begin
                ev = 0;
                if (mbits.size() < DW) mbits.push_back(bus.sdata_i);
                if (bus.ws_i != mws) begin
                    if (armed && !mws) begin
                        left_ok = mbits.size() == DW;
                        if (left_ok) lw = pack(); else ee = 1;
                    end else if (armed && mws && left_ok) begin
                        if (mbits.size() == DW) begin el = lw; er = pack(); ev = 1; end
                        else ee = 1;
                        left_ok = 0;
                    end
                    if (mws && !bus.ws_i) armed = 1;
                    mbits.delete();
                end
                mws = bus.ws_i;
            end
        end
    end

    initial forever begin
        @(negedge sclk);
        chk("left_o", 32'(bus.left_o), 32'(el));
        chk("right_o", 32'(bus.right_o), 32'(er));
        chk("valid_o", 32'(bus.valid_o), 32'(ev));
        chk("err_o", 32'(bus.err_o), 32'(ee));
        if (bus.valid_o) begin
            cap_l.push_back(bus.left_o);
            cap_r.push_back(bus.right_o);
        end
    end

    task automatic add_slot(input logic w, input int len, input logic [31:0] v);
        for (int i = 0; i < len; i++) begin
            ws_q.push_back(w);
            bit_q.push_back(v[(len - 1 - i) % 32]);
        end
    endtask

    // sdata lags ws by one cycle so the MSB lands one sclk after each ws change
    task automatic play(input int rst_at);
        for (int k = 0; k < ws_q.size(); k++) begin
            @(negedge sclk);
            if (k == rst_at) begin
                rst_n = 1'b0;
                break;
            end
            bus.ws_i = ws_q[k];
            bus.sdata_i = last_bit;
            last_bit = bit_q[k];
        end
        ws_q.delete();
        bit_q.delete();
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rst_n = 1'b0;
        repeat (4) begin
            @(negedge sclk);
            bus.ws_i = 1'($urandom);
            bus.sdata_i = 1'($urandom);
        end
        #1;
        chk("rst_left", 32'(bus.left_o), 0);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        @(negedge sclk);
        rst_n = 1'b1;
        bus.ws_i = 1'b1;
        last_bit = 1'b0;
        cap_l.delete();
        cap_r.delete();
    endtask

    task automatic settle();
        repeat (3) @(negedge sclk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lens[10] = '{8, 15, 16, 16, 16, 16, 17, 20, 24, 40};
        int at;
        bus.ws_i = 1'b0;
        bus.sdata_i = 1'b0;
        repeat (2) @(negedge sclk);
        // nominal frames after a sync point reached mid-right slot
        do_reset();
        add_slot(1, 5, $urandom);
        add_slot(0, 16, 32'hDEAD);
        add_slot(1, 16, 32'hBEEF);
        add_slot(0, 16, 32'hBEEF);
        add_slot(1, 16, 32'hDEAD);
        add_slot(0, 1, 0);
        play(-1);
        settle();
        chk("nom_frames", cap_l.size(), 2);
        if (cap_l.size() == 2) begin
            chk("nom_l0", 32'(cap_l[0]), 32'hDEAD);
            chk("nom_r0", 32'(cap_r[0]), 32'hBEEF);
            chk("nom_l1", 32'(cap_l[1]), 32'hBEEF);
            chk("nom_r1", 32'(cap_r[1]), 32'hDEAD);
        end
        // long slots keep their leading bits
        do_reset();
        add_slot(1, 3, $urandom);
        add_slot(0, 24, 32'hDEAD55);
        add_slot(1, 24, 32'hBEEF77);
        add_slot(0, 1, 0);
        play(-1);
        settle();
        chk("long_frames", cap_l.size(), 1);
        if (cap_l.size() == 1) begin
            chk("long_l", 32'(cap_l[0]), 32'hDEAD);
            chk("long_r", 32'(cap_r[0]), 32'hBEEF);
        end
        chk("long_err", 32'(bus.err_o), 0);
        // short left slot, then a good frame
        do_reset();
        add_slot(1, 4, $urandom);
        add_slot(0, 8, 32'h3C);
        add_slot(1, 16, $urandom);
        add_slot(0, 16, 32'hA5A5);
        add_slot(1, 16, 32'h5A5A);
        add_slot(0, 1, 0);
        play(-1);
        settle();
        chk("short_frames", cap_l.size(), 1);
        if (cap_l.size() == 1) begin
            chk("short_l", 32'(cap_l[0]), 32'hA5A5);
            chk("short_r", 32'(cap_r[0]), 32'h5A5A);
        end
        chk("short_err", 32'(bus.err_o), 1);
        // reset at bit 7 of a right slot while the error flag is set
        do_reset();
        add_slot(1, 3, $urandom);
        add_slot(0, 8, $urandom);
        add_slot(1, 16, $urandom);
        add_slot(0, 16, 32'hA5A5);
        at = ws_q.size() + 7;
        add_slot(1, 16, 32'h5A5A);
        play(at);
        repeat (2) @(negedge sclk);
        #1;
        chk("mid_rst_err", 32'(bus.err_o), 0);
        chk("mid_rst_left", 32'(bus.left_o), 0);
        chk("mid_rst_right", 32'(bus.right_o), 0);
        @(negedge sclk);
        rst_n = 1'b1;
        cap_l.delete();
        cap_r.delete();
        add_slot(1, 6, $urandom);
        add_slot(0, 16, 32'h1234);
        add_slot(1, 16, 32'h5678);
        add_slot(0, 1, 0);
        play(-1);
        settle();
        chk("resync_frames", cap_l.size(), 1);
        if (cap_l.size() == 1) begin
            chk("resync_l", 32'(cap_l[0]), 32'h1234);
            chk("resync_r", 32'(cap_r[0]), 32'h5678);
        end
        // randomized slot lengths and contents against the model
        repeat (4) begin
            do_reset();
            add_slot(1, $urandom_range(1, 10), $urandom);
            for (int s = 0; s < 40; s++)
                add_slot(1'(s % 2), lens[$urandom_range(0, 9)], $urandom);
            add_slot(0, 1, 0);
            play(-1);
            settle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter: DATA_WIDTH, 16, number of bits captured per channel slot (MSB first).
REQ-002 Port: sclk_i  input  1  serial bit clock; the only clock; all state updates on its rising edge.
REQ-003 Port: rst_n_i  input  1  asynchronous active-low reset.
REQ-004 Port: ws_i  input  1  word select (0 = left slot, 1 = right slot), driven on sclk falling edge.
REQ-005 Port: sdata_i  input  1  serial data, Philips I2S format: MSB one sclk after each ws transition.
REQ-006 Port: left_o  output  DATA_WIDTH  last complete left sample.
REQ-007 Port: right_o  output  DATA_WIDTH  last complete right sample.
REQ-008 Port: valid_o  output  1  one-cycle pulse when left_o/right_o hold a new frame.
REQ-009 Port: err_o  output  1  sticky framing-error flag, drives errorLED at top level.

Function
REQ-010 ws_d: ws_i registered once on each sclk_i rising edge; each bit sampled belongs to channel ws_d.
REQ-011 Slot boundary: rising edge where ws_i != ws_d; the bit sampled at that edge is the LSB-position bit of the ending slot.
REQ-012 State machine: SYNC, LEFT, RIGHT.
REQ-013 SYNC: ignore data; on edge with ws_d=1, ws_i=0 -> LEFT with bit count 0; no other exit.
REQ-014 LEFT: shift sdata_i into the shift register MSB-first while the slot count < DATA_WIDTH; count saturates at DATA_WIDTH.
REQ-015 Bits beyond DATA_WIDTH in a slot are ignored (long slot, not an error); e.g. 24-bit slot keeps its first 16 bits.
REQ-016 LEFT boundary (ws_d=0, ws_i=1): if count including this edge's bit >= DATA_WIDTH, latch word into left holding register, clear count, -> RIGHT.
REQ-017 RIGHT boundary (ws_d=1, ws_i=0): if count including this edge's bit >= DATA_WIDTH, at this same edge load left_o from holding register, right_o from the completed word, assert valid_o; clear count, -> LEFT.
REQ-018 valid_o high for exactly one sclk_i cycle per complete frame; frames arrive back-to-back with no gap cycles required.
REQ-019 Short slot (boundary with count < DATA_WIDTH, LEFT or RIGHT): set err_o, discard partial frame, no valid_o, -> SYNC (the RIGHT short-slot boundary itself, being a falling ws edge, counts as the SYNC exit edge, so state -> LEFT).
REQ-020 err_o remains 1 until reset; subsequent good frames still produce valid_o.
REQ-021 left_o/right_o change only together, only on a valid_o edge; otherwise hold.
REQ-022 ws_i constant (no boundary) indefinitely: no output change, count saturates, no error.
REQ-023 No latency beyond REQ-017: the right LSB and valid_o appear on the same rising edge.

Reset
REQ-024 rst_n_i low asynchronously forces: state SYNC, ws_d=0, count 0, shift/holding registers 0, left_o=0, right_o=0, valid_o=0, err_o=0.
REQ-025 Reset asserted mid-slot discards the partial frame; after release, resynchronisation requires a fresh ws 1->0 edge.
REQ-026 Release of rst_n_i is assumed synchronous to sclk_i at top level; no internal synchroniser is required.

Verification
REQ-027 Reset: hold rst_n_i low 4 cycles with random ws/sdata -> all outputs 0, no valid_o.
REQ-028 Nominal: 16-bit slots, sync frame then left 16'hDEAD, right 16'hBEEF -> single valid_o pulse at ws 1->0 edge, left_o=16'hDEAD, right_o=16'hBEEF; next frame 16'hBEEF/16'hDEAD -> outputs swap on next pulse.
REQ-029 Sync: first ws 1->0 edge seen 5 cycles after reset mid-right slot -> no valid_o until the end of the following complete left+right frame.
REQ-030 Long slot: 24-bit slots, left 24'hDEAD55, right 24'hBEEF77 -> left_o=16'hDEAD, right_o=16'hBEEF, err_o=0.
REQ-031 Short slot: 8-bit left slot then good frame A5A5/5A5A -> err_o=1 at short boundary, no valid_o for the broken frame, then valid_o with 16'hA5A5/16'h5A5A, err_o stays 1.
REQ-032 Reset mid-frame: assert rst_n_i at bit 7 of right slot after err_o=1 -> err_o=0, outputs 0, next valid_o only after a full resync.
